// File: rtl/buf_pkg.sv
// ----------------------------------------------------------------------------
// buf_pkg
// Shared constants for the ping-pong frame buffer.
//   DATA_WIDTH_DEF : default sample width in bits
//   ADDR_WIDTH_DEF : default log2 of the frame depth (samples per bank)
//   OVR_WIDTH_DEF  : default width of the dropped-frame counter
//   NUM_BANKS      : number of frame banks (ping and pong)
// ----------------------------------------------------------------------------
package buf_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ADDR_WIDTH_DEF = 3;
   localparam int OVR_WIDTH_DEF  = 8;
   localparam int NUM_BANKS      = 2;

endpackage : buf_pkg

// File: rtl/ram_bank.sv
// ----------------------------------------------------------------------------
// ram_bank
// One frame bank: simple dual-port memory with one write port and one
// registered read port. Contents are not reset; the owner gates visibility.
// Ports:
//   clk : clock
//   we  : write enable
//   wa  : write address
//   wd  : write data
//   re  : read enable (read register holds its value when low)
//   ra  : read address
//   rd  : registered read data (1-cycle latency)
// ----------------------------------------------------------------------------
module ram_bank
   import buf_pkg::*;
#(
   parameter int DW = DATA_WIDTH_DEF,
   parameter int AW = ADDR_WIDTH_DEF
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic          re,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rd
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= wd;
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         rd <= mem[ra];
      end
   end

endmodule : ram_bank

// File: rtl/pingpong_frame_buf.sv
// ----------------------------------------------------------------------------
// pingpong_frame_buf
// Double-buffered frame store. The writer fills the write bank one sample per
// cycle; a completed frame is handed to the reader by swapping banks, or is
// dropped (and counted) when the reader still holds the previous frame.
// Ports:
//   CLK     : clock, rising edge
//   RST     : asynchronous active-high reset
//   WRITE   : write strobe, one sample per cycle
//   Di      : write data
//   READ    : read enable
//   A       : read address within the read bank
//   RELEASE : one-cycle pulse, reader returns the read bank
//   Do      : read data, 1-cycle latency, zero when no valid read
//   FULL    : one-cycle pulse on each bank swap
//   READY   : a completed frame is held in the read bank
//   OVERRUN : one-cycle pulse when a completed frame is dropped
//   OVR_CNT : saturating count of dropped frames
// ----------------------------------------------------------------------------
module pingpong_frame_buf
   import buf_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int OVR_WIDTH  = OVR_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WRITE,
   input  logic [DATA_WIDTH-1:0] Di,
   input  logic                  READ,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic                  RELEASE,
   output logic [DATA_WIDTH-1:0] Do,
   output logic                  FULL,
   output logic                  READY,
   output logic                  OVERRUN,
   output logic [OVR_WIDTH-1:0]  OVR_CNT
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [OVR_WIDTH-1:0]  CNT_MAX   = '1;

   logic                  wb_reg,       wb_next;
   logic [ADDR_WIDTH-1:0] wr_addr_reg,  wr_addr_next;
   logic                  ready_reg,    ready_next;
   logic                  full_reg,     full_next;
   logic                  overrun_reg,  overrun_next;
   logic [OVR_WIDTH-1:0]  ovr_cnt_reg,  ovr_cnt_next;
   logic                  rd_valid_reg, rd_valid_next;
   logic                  rd_sel_reg;

   logic complete;
   logic swap;
   logic drop;

   logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];

   // Writes only ever target bank wb; the read port of the other bank is the
   // only one enabled, so the held frame cannot be disturbed.
   generate
      for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         ram_bank #(
            .DW (DATA_WIDTH),
            .AW (ADDR_WIDTH)
         ) u_bank (
            .clk (CLK),
            .we  (WRITE && (wb_reg == 1'(gi))),
            .wa  (wr_addr_reg),
            .wd  (Di),
            .re  (READ && ready_reg && (wb_reg != 1'(gi))),
            .ra  (A),
            .rd  (bank_q[gi])
         );
      end
   endgenerate

   always_comb begin
      complete      = WRITE && (wr_addr_reg == LAST_ADDR);
      swap          = complete && (!ready_reg || RELEASE);
      drop          = complete && ready_reg && !RELEASE;

      wb_next       = wb_reg ^ swap;
      // Address wraps naturally, so a dropped frame refills from address 0.
      wr_addr_next  = WRITE ? wr_addr_reg + 1'b1 : wr_addr_reg;
      full_next     = swap;
      overrun_next  = drop;
      rd_valid_next = READ && ready_reg;

      ready_next    = ready_reg;
      if (swap) begin
         ready_next = 1'b1;
      end else if (RELEASE && !complete) begin
         ready_next = 1'b0;
      end

      ovr_cnt_next  = ovr_cnt_reg;
      if (drop && (ovr_cnt_reg != CNT_MAX)) begin
         ovr_cnt_next = ovr_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wb_reg       <= 1'b0;
         wr_addr_reg  <= '0;
         ready_reg    <= 1'b0;
         full_reg     <= 1'b0;
         overrun_reg  <= 1'b0;
         ovr_cnt_reg  <= '0;
         rd_valid_reg <= 1'b0;
         rd_sel_reg   <= 1'b0;
      end else begin
         wb_reg       <= wb_next;
         wr_addr_reg  <= wr_addr_next;
         ready_reg    <= ready_next;
         full_reg     <= full_next;
         overrun_reg  <= overrun_next;
         ovr_cnt_reg  <= ovr_cnt_next;
         rd_valid_reg <= rd_valid_next;
         // Captured with the pre-swap pointer so a read in the swap cycle
         // still returns the old frame.
         rd_sel_reg   <= ~wb_reg;
      end
   end

   // The RAM read register has no reset; the validity flag does, which keeps
   // Do at zero immediately on reset and whenever no valid read occurred.
   assign Do      = rd_valid_reg ? bank_q[rd_sel_reg] : '0;
   assign FULL    = full_reg;
   assign READY   = ready_reg;
   assign OVERRUN = overrun_reg;
   assign OVR_CNT = ovr_cnt_reg;

endmodule : pingpong_frame_buf

// File: tb/tb_pingpong_frame_buf.sv
// ----------------------------------------------------------------------------
// tb_pingpong_frame_buf
// Self-checking bench: frame-level reference model (current partial frame,
// frame held by the reader, drop counter) compared every cycle, plus directed
// literal expectations and a randomized phase.
// ----------------------------------------------------------------------------
module tb_pingpong_frame_buf;

   localparam int DW    = 16;
   localparam int AW    = 3;
   localparam int OW    = 2;
   localparam int DEPTH = 8;
   localparam int CMAX  = 3;

   logic          CLK = 1'b0;
   logic          RST;
   logic          WRITE;
   logic [DW-1:0] Di;
   logic          READ;
   logic [AW-1:0] A;
   logic          RELEASE;
   logic [DW-1:0] Do;
   logic          FULL;
   logic          READY;
   logic          OVERRUN;
   logic [OW-1:0] OVR_CNT;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [DW-1:0] m_cur  [DEPTH];
   logic [DW-1:0] m_held [DEPTH];
   int            m_len;
   bit            m_ready;
   int            m_cnt;

   pingpong_frame_buf #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .OVR_WIDTH  (OW)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .WRITE   (WRITE),
      .Di      (Di),
      .READ    (READ),
      .A       (A),
      .RELEASE (RELEASE),
      .Do      (Do),
      .FULL    (FULL),
      .READY   (READY),
      .OVERRUN (OVERRUN),
      .OVR_CNT (OVR_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, predict from the frame-level rules,
   // advance, then compare every output.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                       input logic [AW-1:0] a, input bit rel);
      logic [DW-1:0] e_do;
      bit e_full, e_ovr, comp;
      WRITE = w; Di = d; READ = r; A = a; RELEASE = rel;
      e_do   = (r && m_ready) ? m_held[a] : '0;
      e_full = 0;
      e_ovr  = 0;
      comp   = w && (m_len == DEPTH - 1);
      if (w) m_cur[m_len] = d;
      if (comp) begin
         if (!m_ready || rel) begin
            m_held  = m_cur;
            m_ready = 1;
            e_full  = 1;
         end else begin
            e_ovr = 1;
            if (m_cnt < CMAX) m_cnt++;
         end
         m_len = 0;
      end else begin
         if (w) m_len++;
         if (rel && m_ready) m_ready = 0;
      end
      @(posedge CLK);
      #1;
      chk("do",      32'(Do),      32'(e_do));
      chk("full",    32'(FULL),    32'(e_full));
      chk("ready",   32'(READY),   32'(m_ready));
      chk("overrun", 32'(OVERRUN), 32'(e_ovr));
      chk("ovr_cnt", 32'(OVR_CNT), 32'(m_cnt));
      if (FULL && OVERRUN) chk("full_and_overrun", 32'(1), 32'(0));
   endtask

   task automatic idle();
      step(0, '0, 0, '0, 0);
   endtask

   // Asserted mid-cycle; outputs must clear without waiting for an edge.
   task automatic do_reset();
      RST = 1'b1;
      WRITE = 0; Di = '0; READ = 0; A = '0; RELEASE = 0;
      #1;
      chk("rst_do",      32'(Do),      32'(0));
      chk("rst_full",    32'(FULL),    32'(0));
      chk("rst_ready",   32'(READY),   32'(0));
      chk("rst_overrun", 32'(OVERRUN), 32'(0));
      chk("rst_ovr_cnt", 32'(OVR_CNT), 32'(0));
      m_len = 0; m_ready = 0; m_cnt = 0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b0;
      WRITE = 0; Di = '0; READ = 0; A = '0; RELEASE = 0;
      m_len = 0; m_ready = 0; m_cnt = 0;
      #3;
      do_reset();

      // First frame 0x0001..0x0008 swaps in
      for (int i = 0; i < DEPTH; i++) step(1, DW'(i + 1), 0, '0, 0);
      chk("f1_full",  32'(FULL),  32'(1));
      chk("f1_ready", 32'(READY), 32'(1));
      for (int i = 0; i < DEPTH; i++) begin
         step(0, '0, 1, AW'(i), 0);
         chk("f1_read", 32'(Do), 32'(i + 1));
      end

      // Second frame without release is dropped
      for (int i = 0; i < DEPTH; i++) step(1, DW'(i + 9), 0, '0, 0);
      chk("f2_overrun", 32'(OVERRUN), 32'(1));
      chk("f2_cnt",     32'(OVR_CNT), 32'(1));
      chk("f2_full",    32'(FULL),    32'(0));
      step(0, '0, 1, 3'd0, 0);
      chk("f2_read0", 32'(Do), 32'h0001);
      step(0, '0, 1, 3'd7, 0);
      chk("f2_read7", 32'(Do), 32'h0008);

      // Third frame swaps with release in the completing cycle; A=7 read then
      for (int i = 0; i < DEPTH - 1; i++) step(1, DW'(16'h0011 + i), 0, '0, 0);
      step(1, 16'h0018, 1, 3'd7, 1);
      chk("f3_full",     32'(FULL),  32'(1));
      chk("f3_ready",    32'(READY), 32'(1));
      chk("f3_swap_old", 32'(Do),    32'h0008);
      step(0, '0, 1, 3'd7, 0);
      chk("f3_new7", 32'(Do), 32'h0018);
      step(0, '0, 1, 3'd0, 0);
      chk("f3_new0", 32'(Do), 32'h0011);

      // Reset mid-frame discards the partial frame
      for (int i = 0; i < 4; i++) step(1, DW'(16'h00A0 + i), 0, '0, 0);
      @(negedge CLK);
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1, DW'(16'h0031 + i), 0, '0, 0);
      chk("rs_full", 32'(FULL), 32'(1));
      step(0, '0, 1, 3'd0, 0);
      chk("rs_read0", 32'(Do), 32'h0031);

      // Five drops saturate the 2-bit counter
      for (int f = 0; f < 5; f++)
         for (int i = 0; i < DEPTH; i++) step(1, DW'(16'h0100 * (f + 1) + i), 0, '0, 0);
      chk("sat_cnt", 32'(OVR_CNT), 32'(3));
      step(0, '0, 1, 3'd3, 0);
      chk("sat_read3", 32'(Do), 32'h0034);
      step(0, '0, 0, '0, 1);
      chk("rel_ready", 32'(READY), 32'(0));
      step(0, '0, 1, 3'd0, 0);
      chk("rel_read_zero", 32'(Do), 32'(0));
      // Release with nothing held is ignored
      step(0, '0, 0, '0, 1);
      idle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            @(negedge CLK);
            do_reset();
         end else begin
            step($urandom_range(0, 9) < 8, DW'($urandom), $urandom_range(0, 1) == 1,
                 AW'($urandom), $urandom_range(0, 7) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_pingpong_frame_buf
